// File: rtl/display_scan_if.sv
// Bundle between a digit-code host and the display scan driver:
// the host writes digit codes in, the decoder-facing code bus and digit selects come out.
interface display_scan_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic                  enable;
    logic                  wr_en;
    logic [2:0]            wr_addr;
    logic [2:0]            wr_data;
    logic                  A;
    logic                  B;
    logic                  C;
    logic [NUM_DIGITS-1:0] DIG;
    logic                  frame_done;

    modport master (
        output enable, wr_en, wr_addr, wr_data,
        input  A, B, C, DIG, frame_done
    );

    modport slave (
        input  enable, wr_en, wr_addr, wr_data,
        output A, B, C, DIG, frame_done
    );
endinterface

// File: rtl/display_scan_driver.sv
// Time-multiplexes NUM_DIGITS 3-bit codes onto one A/B/C bus with active-low digit selects,
// a blanking guard at the start of every slot and frame-boundary commit of new codes.
//
// state | meaning
// ------+-----------------------------------------------------------
// BLANK | cnt < BLANK_CYCLES: all digits off, code bus settling
// SHOW  | cnt >= BLANK_CYCLES: digit idx driven low, code held
module display_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input logic          clk,
    input logic          rst,
    display_scan_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(SCAN_DIV);

    localparam logic [3:0]       NUM_DIGITS_V = 4'(NUM_DIGITS);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK    = CNT_W'(BLANK_CYCLES);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_inc;
    logic [IDX_W-1:0]      idx;
    logic [2:0]            shadow     [NUM_DIGITS];
    logic [2:0]            shadow_nxt [NUM_DIGITS];
    logic [2:0]            active     [NUM_DIGITS];
    logic [2:0]            code_q;
    logic [NUM_DIGITS-1:0] dig_q;
    logic [NUM_DIGITS-1:0] dig_sel;
    logic                  frame_done_q;

    // Post-write view of the shadow bank; a commit on the same edge picks up the new code.
    always_comb begin
        shadow_nxt = shadow;
        if (bus.wr_en && ({1'b0, bus.wr_addr} < NUM_DIGITS_V)) begin
            shadow_nxt[bus.wr_addr[IDX_W-1:0]] = bus.wr_data;
        end
    end

    always_comb begin
        cnt_inc = cnt + 1'b1;
        dig_sel = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                dig_sel[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_BLANK;
            cnt          <= '0;
            idx          <= '0;
            shadow       <= '{default: '0};
            active       <= '{default: '0};
            code_q       <= '0;
            dig_q        <= '1;
            frame_done_q <= 1'b0;
        end else begin
            shadow       <= shadow_nxt;
            frame_done_q <= 1'b0;
            if (!bus.enable) begin
                state  <= ST_BLANK;
                cnt    <= '0;
                idx    <= '0;
                active <= shadow_nxt;
                code_q <= active[0];
                dig_q  <= '1;
            end else begin
                // Outputs reflect the current cnt/idx; the code stays fixed across the slot.
                code_q <= active[idx];
                dig_q  <= (state == ST_SHOW) ? dig_sel : '1;
                if (cnt == CNT_LAST) begin
                    cnt   <= '0;
                    state <= ST_BLANK;
                    if (idx == IDX_LAST) begin
                        idx          <= '0;
                        active       <= shadow_nxt;
                        frame_done_q <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end else begin
                    cnt   <= cnt_inc;
                    state <= (cnt_inc < CNT_BLANK) ? ST_BLANK : ST_SHOW;
                end
            end
        end
    end

    assign bus.A          = code_q[2];
    assign bus.B          = code_q[1];
    assign bus.C          = code_q[0];
    assign bus.DIG        = dig_q;
    assign bus.frame_done = frame_done_q;
endmodule
